frame_buffer_arbiter: RTL and testbench

FRAME_BUFFER_ARBITER -- requirements
Module: frame_buffer_arbiter

---
 rtl/frame_buffer_arbiter.sv | 161 ++++++++++++++++
 tb/tb_frame_buffer_arbiter.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/frame_buffer_arbiter.sv
// Frame-buffer port arbiter: display fetches have strict priority over a
// 4-deep drawing-engine write FIFO sharing one synchronous-read memory port.
module frame_buffer_arbiter #(
  parameter int H_ACTIVE = 800,
  parameter int V_ACTIVE = 600,
  parameter int DATA_W   = 8
) (
  input  logic              Clock,
  input  logic              Reset_n,
  input  logic              disp_req,
  input  logic [10:0]       disp_x,
  input  logic [9:0]        disp_y,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [10:0]       wr_x,
  input  logic [9:0]        wr_y,
  input  logic [DATA_W-1:0] wr_data,
  output logic [18:0]       mem_addr,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              pix_valid,
  output logic [DATA_W-1:0] pix_data,
  output logic [2:0]        fifo_level,
  output logic              err_oob
);

  localparam int AW    = 19;
  localparam int DEPTH = 4;

  typedef enum logic [1:0] {G_IDLE, G_READ, G_WRITE} grant_e;

  typedef struct packed {
    logic [AW-1:0]     addr;
    logic [DATA_W-1:0] data;
  } wr_entry_t;

  // Shift-add for the default 800-pixel line (512 + 256 + 32).
  function automatic logic [AW-1:0] lin_addr(input logic [9:0] y, input logic [10:0] x);
    logic [AW-1:0] ye, xe;
    ye = AW'(y);
    xe = AW'(x);
    if (H_ACTIVE == 800) lin_addr = (ye << 9) + (ye << 8) + (ye << 5) + xe;
    else                 lin_addr = ye * AW'(H_ACTIVE) + xe;
  endfunction

  grant_e            state_q, state_d;
  wr_entry_t         fifo_mem_q [DEPTH];
  wr_entry_t         fifo_mem_d [DEPTH];
  logic [1:0]        rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [2:0]        level_q, level_d;
  logic              err_q, err_d;
  logic [AW-1:0]     stage_addr_q, stage_addr_d;
  logic [DATA_W-1:0] stage_data_q, stage_data_d;
  logic [AW-1:0]     mem_addr_q, mem_addr_d;
  logic              mem_we_q, mem_we_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic              rd_issue_q, rd_issue_d;
  logic              rd_wait_q, rd_wait_d;
  logic              pix_valid_q, pix_valid_d;
  logic [DATA_W-1:0] pix_data_q, pix_data_d;

  logic push, oob, enq, pop;

  assign wr_ready = (level_q < 3'(DEPTH));

  always_comb begin
    // NOTE: every signal gets a default before any branch so no latch is inferred.
    state_d      = state_q;
    fifo_mem_d   = fifo_mem_q;
    rd_ptr_d     = rd_ptr_q;
    wr_ptr_d     = wr_ptr_q;
    err_d        = err_q;
    stage_addr_d = stage_addr_q;
    stage_data_d = stage_data_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    pix_data_d   = pix_data_q;

    push = wr_valid && wr_ready;
    oob  = (int'(wr_x) >= H_ACTIVE) || (int'(wr_y) >= V_ACTIVE);
    enq  = push && !oob;

    if (disp_req)          state_d = G_READ;
    else if (level_q != 0) state_d = G_WRITE;
    else                   state_d = G_IDLE;
    pop = (state_d == G_WRITE);

    // The granting edge latches the winner's address into the stage register;
    // the memory port is driven from it one clock later.
    if (state_d == G_READ) stage_addr_d = lin_addr(disp_y, disp_x);
    if (pop) begin
      stage_addr_d = fifo_mem_q[rd_ptr_q].addr;
      stage_data_d = fifo_mem_q[rd_ptr_q].data;
      rd_ptr_d     = rd_ptr_q + 2'd1;
    end
    if (enq) begin
      fifo_mem_d[wr_ptr_q] = '{addr: lin_addr(wr_y, wr_x), data: wr_data};
      wr_ptr_d             = wr_ptr_q + 2'd1;
    end
    level_d = level_q + 3'(enq) - 3'(pop);
    if (push && oob) err_d = 1'b1;

    mem_we_d = (state_q == G_WRITE);
    if (state_q != G_IDLE)  mem_addr_d  = stage_addr_q;
    if (state_q == G_WRITE) mem_wdata_d = stage_data_q;

    rd_issue_d  = (state_q == G_READ);
    rd_wait_d   = rd_issue_q;
    pix_valid_d = rd_wait_q;
    if (rd_wait_q) pix_data_d = mem_rdata;
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge Clock) begin
    if (!Reset_n) begin
      state_q     <= G_IDLE;
      rd_ptr_q    <= '0;
      wr_ptr_q    <= '0;
      level_q     <= '0;
      err_q       <= 1'b0;
      mem_addr_q  <= '0;
      mem_we_q    <= 1'b0;
      mem_wdata_q <= '0;
      rd_issue_q  <= 1'b0;
      rd_wait_q   <= 1'b0;
      pix_valid_q <= 1'b0;
      pix_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      rd_ptr_q    <= rd_ptr_d;
      wr_ptr_q    <= wr_ptr_d;
      level_q     <= level_d;
      err_q       <= err_d;
      mem_addr_q  <= mem_addr_d;
      mem_we_q    <= mem_we_d;
      mem_wdata_q <= mem_wdata_d;
      rd_issue_q  <= rd_issue_d;
      rd_wait_q   <= rd_wait_d;
      pix_valid_q <= pix_valid_d;
      pix_data_q  <= pix_data_d;
    end
  end

  // NOTE: FIFO storage and the stage register carry no reset; pointers and the
  // grant state already make their contents unobservable after reset.
  always_ff @(posedge Clock) begin
    fifo_mem_q   <= fifo_mem_d;
    stage_addr_q <= stage_addr_d;
    stage_data_q <= stage_data_d;
  end

  assign mem_addr   = mem_addr_q;
  assign mem_we     = mem_we_q;
  assign mem_wdata  = mem_wdata_q;
  assign pix_valid  = pix_valid_q;
  assign pix_data   = pix_data_q;
  assign fifo_level = level_q;
  assign err_oob    = err_q;

endmodule

// File: tb/tb_frame_buffer_arbiter.sv
// Bench for frame_buffer_arbiter: directed scenarios plus random traffic, all
// outputs compared every cycle against a queue-based reference model.
module tb_frame_buffer_arbiter;

  logic        Clock = 1'b0;
  logic        Reset_n;
  logic        disp_req;
  logic [10:0] disp_x;
  logic [9:0]  disp_y;
  logic        wr_valid;
  logic        wr_ready;
  logic [10:0] wr_x;
  logic [9:0]  wr_y;
  logic [7:0]  wr_data;
  logic [18:0] mem_addr;
  logic        mem_we;
  logic [7:0]  mem_wdata;
  logic [7:0]  mem_rdata;
  logic        pix_valid;
  logic [7:0]  pix_data;
  logic [2:0]  fifo_level;
  logic        err_oob;

  frame_buffer_arbiter #(.H_ACTIVE(800), .V_ACTIVE(600), .DATA_W(8)) dut (
    .Clock(Clock), .Reset_n(Reset_n),
    .disp_req(disp_req), .disp_x(disp_x), .disp_y(disp_y),
    .wr_valid(wr_valid), .wr_ready(wr_ready),
    .wr_x(wr_x), .wr_y(wr_y), .wr_data(wr_data),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .pix_valid(pix_valid), .pix_data(pix_data),
    .fifo_level(fifo_level), .err_oob(err_oob)
  );

  always #5 Clock = ~Clock;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Memory content is a fixed function of address, so read data is predictable.
  function automatic logic [7:0] mem_hash(input int a);
    return 8'((a * 13) ^ (a >> 7));
  endfunction

  always @(posedge Clock) mem_rdata <= mem_hash(int'(mem_addr));

  // ---------------- reference model ----------------
  typedef struct { int addr; int data; } wr_t;
  wr_t mq[$];
  bit  m_valid = 0;
  int  m_stage = 0;              // 0 none, 1 display fetch, 2 write
  int  m_saddr = 0, m_sdata = 0;
  bit  p1_v = 0, p2_v = 0;
  int  p1_a = 0, p2_a = 0;
  bit  e_we = 0, e_pv = 0, m_err = 0;
  int  e_addr = 0, e_wdata = 0, e_pd = 0;

  // Inputs as seen by the rising edge; the model advances on the following falling edge.
  logic        s_rst = 1'b1, s_disp = 1'b0, s_wv = 1'b0;
  logic [10:0] s_dx = '0, s_wx = '0;
  logic [9:0]  s_dy = '0, s_wy = '0;
  logic [7:0]  s_wd = '0;

  always @(posedge Clock) begin
    s_rst  <= Reset_n;  s_disp <= disp_req;
    s_dx   <= disp_x;   s_dy   <= disp_y;
    s_wv   <= wr_valid; s_wx   <= wr_x;
    s_wy   <= wr_y;     s_wd   <= wr_data;
  end

  task automatic model_step();
    int  sz;
    wr_t w;
    if (s_rst === 1'b0) begin
      mq.delete();
      m_valid = 1; m_stage = 0; m_err = 0;
      p1_v = 0; p2_v = 0; e_we = 0; e_pv = 0;
      e_addr = 0; e_wdata = 0; e_pd = 0;
    end else begin
      e_pv = p2_v;
      if (p2_v) e_pd = mem_hash(p2_a);
      p2_v = p1_v; p2_a = p1_a;
      p1_v = (m_stage == 1); p1_a = m_saddr;
      e_we = (m_stage == 2);
      if (m_stage != 0) e_addr  = m_saddr;
      if (m_stage == 2) e_wdata = m_sdata;
      sz = mq.size();
      if (s_disp === 1'b1) begin
        m_stage = 1;
        m_saddr = (int'(s_dy) * 800 + int'(s_dx)) % 524288;
      end else if (sz > 0) begin
        m_stage = 2;
        w = mq.pop_front();
        m_saddr = w.addr; m_sdata = w.data;
      end else begin
        m_stage = 0;
      end
      if (s_wv === 1'b1 && sz < 4) begin
        if (int'(s_wx) >= 800 || int'(s_wy) >= 600) m_err = 1;
        else begin
          w.addr = int'(s_wy) * 800 + int'(s_wx);
          w.data = int'(s_wd);
          mq.push_back(w);
        end
      end
    end
  endtask

  always @(negedge Clock) begin
    model_step();
    if (m_valid) begin
      check("fifo_level", 32'(fifo_level), 32'(mq.size()));
      check("wr_ready",   32'(wr_ready),   32'(mq.size() < 4));
      check("mem_we",     32'(mem_we),     32'(e_we));
      check("mem_addr",   32'(mem_addr),   32'(e_addr));
      check("mem_wdata",  32'(mem_wdata),  32'(e_wdata));
      check("pix_valid",  32'(pix_valid),  32'(e_pv));
      check("pix_data",   32'(pix_data),   32'(e_pd));
      check("err_oob",    32'(err_oob),    32'(m_err));
    end
  end

  int we_log[$];
  always @(negedge Clock) if (mem_we === 1'b1) we_log.push_back(int'(mem_addr));

  // ---------------- stimulus ----------------
  task automatic tick(input int n = 1);
    repeat (n) @(negedge Clock);
  endtask

  task automatic push(input int x, input int y, input int d);
    wr_valid = 1'b1; wr_x = 11'(x); wr_y = 10'(y); wr_data = 8'(d);
    tick();
    wr_valid = 1'b0;
  endtask

  int mark;
  int exp_addrs [4] = '{0, 479999, 1, 800};

  initial begin
    Reset_n = 1'b0; disp_req = 1'b0; disp_x = '0; disp_y = '0;
    wr_valid = 1'b0; wr_x = '0; wr_y = '0; wr_data = '0;
    tick(3);
    Reset_n = 1'b1;
    check("rst_mem_addr", 32'(mem_addr), 0);
    check("rst_mem_we", 32'(mem_we), 0);
    check("rst_pix_valid", 32'(pix_valid), 0);
    check("rst_fifo_level", 32'(fifo_level), 0);
    check("rst_wr_ready", 32'(wr_ready), 1);
    tick(2);

    // Single display fetch at (5,2).
    disp_req = 1'b1; disp_x = 11'd5; disp_y = 10'd2;
    tick();
    disp_req = 1'b0; disp_x = '0; disp_y = '0;
    tick();
    check("rd_addr", 32'(mem_addr), 1605);
    check("rd_we", 32'(mem_we), 0);
    tick();
    check("rd_pix_early", 32'(pix_valid), 0);
    tick();
    check("rd_pix_valid", 32'(pix_valid), 1);
    check("rd_pix_data", 32'(pix_data), 32'(mem_hash(1605)));
    tick();
    check("rd_pix_drop", 32'(pix_valid), 0);

    // Fill during an active line, hold it, then drain in order.
    disp_req = 1'b1; disp_x = 11'd10; disp_y = 10'd20;
    push(0, 0, 8'h11); push(799, 599, 8'h22); push(1, 0, 8'h33); push(0, 1, 8'h44);
    check("full_level", 32'(fifo_level), 4);
    check("full_ready", 32'(wr_ready), 0);
    mark = we_log.size();
    for (int i = 0; i < 1000; i++) begin
      disp_x = 11'($urandom_range(0, 799)); disp_y = 10'($urandom_range(0, 599));
      wr_valid = 1'($urandom); wr_x = 11'($urandom_range(0, 799)); wr_y = 10'($urandom_range(0, 599));
      wr_data = 8'($urandom);
      tick();
    end
    wr_valid = 1'b0;
    check("hold_no_we", 32'(we_log.size() - mark), 0);
    check("hold_level", 32'(fifo_level), 4);
    disp_req = 1'b0;
    tick(4);
    check("drain_level", 32'(fifo_level), 0);
    tick(2);
    check("drain_count", 32'(we_log.size() - mark), 4);
    for (int i = 0; i < 4; i++)
      if (mark + i < we_log.size()) check($sformatf("drain_addr%0d", i), 32'(we_log[mark + i]), 32'(exp_addrs[i]));

    // Out-of-range write.
    check("oob_ready", 32'(wr_ready), 1);
    push(800, 5, 8'h55);
    check("oob_level", 32'(fifo_level), 0);
    check("oob_flag", 32'(err_oob), 1);
    tick(100);
    check("oob_sticky", 32'(err_oob), 1);

    // Push and pop on the same edge at level 3.
    disp_req = 1'b1;
    push(3, 3, 1); push(4, 4, 2); push(5, 5, 3);
    disp_req = 1'b0;
    push(6, 6, 4);
    check("pp_level", 32'(fifo_level), 3);
    check("pp_ready", 32'(wr_ready), 1);
    tick(8);

    // Reset while a write is staged and two entries remain queued.
    disp_req = 1'b1;
    push(7, 7, 5); push(8, 8, 6); push(9, 9, 7);
    disp_req = 1'b0;
    tick();
    check("mid_level", 32'(fifo_level), 2);
    Reset_n = 1'b0;
    tick();
    Reset_n = 1'b1;
    check("rr_mem_addr", 32'(mem_addr), 0);
    check("rr_mem_we", 32'(mem_we), 0);
    check("rr_mem_wdata", 32'(mem_wdata), 0);
    check("rr_pix_valid", 32'(pix_valid), 0);
    check("rr_pix_data", 32'(pix_data), 0);
    check("rr_level", 32'(fifo_level), 0);
    check("rr_err", 32'(err_oob), 0);
    check("rr_ready", 32'(wr_ready), 1);
    mark = we_log.size();
    tick(20);
    check("rr_no_we", 32'(we_log.size() - mark), 0);

    // Random traffic with bursty display requests and occasional resets.
    for (int i = 0; i < 3000; i++) begin
      Reset_n  = ($urandom_range(0, 499) != 0);
      if ($urandom_range(0, 19) == 0) disp_req = ~disp_req;
      disp_x   = 11'($urandom_range(0, 2047));
      disp_y   = 10'($urandom_range(0, 1023));
      wr_valid = 1'($urandom);
      wr_x     = ($urandom_range(0, 9) == 0) ? 11'($urandom_range(0, 2047)) : 11'($urandom_range(0, 799));
      wr_y     = ($urandom_range(0, 9) == 0) ? 10'($urandom_range(0, 1023)) : 10'($urandom_range(0, 599));
      wr_data  = 8'($urandom);
      tick();
    end
    Reset_n = 1'b1; disp_req = 1'b0; wr_valid = 1'b0;
    tick(10);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
